// File: rtl/uart_pkg.sv
// Shared UART definitions: controller state encoding and default framing parameters.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;
  localparam int unsigned DATA_BITS_DEFAULT    = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } uart_state_e;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Serial line plus shift-register drive and status strobes of the UART receive controller.
interface uart_rx_ctrl_if;

  logic rx;
  logic bit_out;
  logic shift_en;
  logic rx_done;
  logic frame_err;
  logic busy;

  modport master (
    input  rx,
    output bit_out,
    output shift_en,
    output rx_done,
    output frame_err,
    output busy
  );

  modport slave (
    output rx,
    input  bit_out,
    input  shift_en,
    input  rx_done,
    input  frame_err,
    input  busy
  );

endinterface

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous input; resets to 1 (idle level).
module bit_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_d, sync_q;

  always_comb begin
    sync_d = {sync_q[0], d_i};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: validates start/stop bits and emits one bit_out/shift_en pair per
// data bit to an external right-shift register; rx_done / frame_err close each frame.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned DATA_BITS    = DATA_BITS_DEFAULT
) (
  input logic            clk,
  input logic            rst,
  uart_rx_ctrl_if.master rx_bus
);

  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW  = $clog2(DATA_BITS + 1);

  localparam logic [BaudW-1:0] BaudHalf = BaudW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);

  logic rxs;

  uart_state_e      state_d, state_q;
  logic [BaudW-1:0] baud_cnt_d, baud_cnt_q;
  logic [BitW-1:0]  bit_cnt_d, bit_cnt_q;
  logic             bit_out_d, bit_out_q;
  logic             shift_en_d, shift_en_q;
  logic             rx_done_d, rx_done_q;
  logic             frame_err_d, frame_err_q;
  logic             busy_d, busy_q;

  bit_sync u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx_bus.rx),
    .q_o (rxs)
  );

  always_comb begin
    state_d     = state_q;
    baud_cnt_d  = baud_cnt_q + BaudW'(1);
    bit_cnt_d   = bit_cnt_q;
    bit_out_d   = bit_out_q;
    shift_en_d  = 1'b0;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        baud_cnt_d = '0;
        if (!rxs) begin
          state_d   = StStart;
          bit_cnt_d = '0;
        end
      end
      StStart: begin
        // Mid start bit: a line that has already returned high was only a glitch.
        if (baud_cnt_q == BaudHalf) begin
          baud_cnt_d = '0;
          state_d    = rxs ? StIdle : StData;
        end
      end
      StData: begin
        if (baud_cnt_q == BaudLast) begin
          baud_cnt_d = '0;
          bit_out_d  = rxs;
          shift_en_d = 1'b1;
          if (bit_cnt_q == BitLast) begin
            bit_cnt_d = '0;
            state_d   = StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + BitW'(1);
          end
        end
      end
      StStop: begin
        if (baud_cnt_q == BaudLast) begin
          baud_cnt_d = '0;
          if (rxs) begin
            rx_done_d = 1'b1;
            state_d   = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StBreak;
          end
        end
      end
      StBreak: begin
        // Stuck-low line must rise before a new start bit is believed.
        baud_cnt_d = '0;
        if (rxs) begin
          state_d = StIdle;
        end
      end
      default: begin
        baud_cnt_d = '0;
        bit_cnt_d  = '0;
        state_d    = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      baud_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      bit_out_q   <= 1'b0;
      shift_en_q  <= 1'b0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      bit_out_q   <= bit_out_d;
      shift_en_q  <= shift_en_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  assign rx_bus.bit_out   = bit_out_q;
  assign rx_bus.shift_en  = shift_en_q;
  assign rx_bus.rx_done   = rx_done_q;
  assign rx_bus.frame_err = frame_err_q;
  assign rx_bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with CLKS_PER_BIT = 16 and an 8-bit right-shift register model.
module tb_uart_rx_ctrl;

  localparam int unsigned C = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_rx_ctrl_if bus ();

  uart_rx_ctrl #(
    .CLKS_PER_BIT (C),
    .DATA_BITS    (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .rx_bus (bus)
  );

  always #5 clk = ~clk;

  // Downstream register: right shift, serial in at the MSB, so the byte lands LSB-first.
  logic [7:0] par_out;
  always @(posedge clk or posedge rst) begin
    if (rst) par_out <= 8'h00;
    else if (bus.shift_en) par_out <= {bus.bit_out, par_out[7:1]};
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  int         shift_cnt = 0, done_cnt = 0, err_cnt = 0, rise_cnt = 0, overlap_cnt = 0;
  int         shift_cyc[$];
  bit         shift_bit[$];
  int         done_cyc[$];
  logic [7:0] done_par[$];
  int         rise_cyc[$];
  logic [7:0] err_par = 8'h00;
  logic       busy_prev = 1'b0;
  int         fall_cyc = 0;

  always @(negedge clk) begin
    if (bus.shift_en) begin
      shift_cnt++;
      shift_cyc.push_back(cyc);
      shift_bit.push_back(bus.bit_out);
    end
    if (bus.rx_done) begin
      done_cnt++;
      done_cyc.push_back(cyc);
      done_par.push_back(par_out);
    end
    if (bus.frame_err) begin
      err_cnt++;
      err_par = par_out;
    end
    if ((bus.shift_en && (bus.rx_done || bus.frame_err)) || (bus.rx_done && bus.frame_err))
      overlap_cnt++;
    if (bus.busy && !busy_prev) begin
      rise_cnt++;
      rise_cyc.push_back(cyc);
    end
    busy_prev = bus.busy;
  end

  task automatic line_bit(input logic v);
    bus.rx = v;
    repeat (C) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    fall_cyc = cyc;
    line_bit(1'b0);
    for (int i = 0; i < 8; i++) line_bit(d[i]);
    line_bit(stop);
  endtask

  task automatic test_reset;
    rst    = 1'b1;
    bus.rx = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (bus.bit_out !== 1'b0) begin
      bad++; $display("FAIL reset_bit_out: got %b want 0", bus.bit_out);
    end
    total++;
    if (bus.shift_en !== 1'b0) begin
      bad++; $display("FAIL reset_shift_en: got %b want 0", bus.shift_en);
    end
    total++;
    if (bus.rx_done !== 1'b0) begin
      bad++; $display("FAIL reset_rx_done: got %b want 0", bus.rx_done);
    end
    total++;
    if (bus.frame_err !== 1'b0) begin
      bad++; $display("FAIL reset_frame_err: got %b want 0", bus.frame_err);
    end
    total++;
    if (bus.busy !== 1'b0) begin
      bad++; $display("FAIL reset_busy: got %b want 0", bus.busy);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_frame_55;
    int sb = shift_cnt, db = done_cnt, eb = err_cnt, rb = rise_cnt, ob = overlap_cnt;
    logic [7:0] bits;
    @(negedge clk);
    send_frame(8'h55, 1'b1);
    for (int k = 0; k < 50 && done_cnt < db + 1; k++) begin
      @(negedge clk); #1;
    end
    total++;
    if (done_cnt - db !== 1) begin
      bad++; $display("FAIL f55_done_count: got %0d want 1", done_cnt - db);
    end
    total++;
    if (shift_cnt - sb !== 8) begin
      bad++; $display("FAIL f55_shift_count: got %0d want 8", shift_cnt - sb);
    end
    if (shift_cnt - sb >= 8 && done_cnt - db >= 1 && rise_cnt - rb >= 1) begin
      for (int i = 0; i < 8; i++) bits[i] = shift_bit[sb + i];
      total++;
      if (bits !== 8'h55) begin
        bad++; $display("FAIL f55_bit_seq: got %h want 55", bits);
      end
      total++;
      if (rise_cyc[rb] - fall_cyc !== 3) begin
        bad++; $display("FAIL f55_pin_latency: got %0d want 3", rise_cyc[rb] - fall_cyc);
      end
      total++;
      if (shift_cyc[sb] - rise_cyc[rb] !== 24) begin
        bad++; $display("FAIL f55_first_shift: got %0d want 24", shift_cyc[sb] - rise_cyc[rb]);
      end
      for (int i = 1; i < 8; i++) begin
        total++;
        if (shift_cyc[sb + i] - shift_cyc[sb + i - 1] !== 16) begin
          bad++;
          $display("FAIL f55_spacing[%0d]: got %0d want 16", i,
                   shift_cyc[sb + i] - shift_cyc[sb + i - 1]);
        end
      end
      total++;
      if (done_cyc[db] - shift_cyc[sb + 7] !== 16) begin
        bad++; $display("FAIL f55_done_delay: got %0d want 16", done_cyc[db] - shift_cyc[sb + 7]);
      end
      total++;
      if (done_par[db] !== 8'h55) begin
        bad++; $display("FAIL f55_par_out: got %h want 55", done_par[db]);
      end
    end
    total++;
    if (err_cnt - eb !== 0) begin
      bad++; $display("FAIL f55_frame_err: got %0d want 0", err_cnt - eb);
    end
    total++;
    if (overlap_cnt - ob !== 0) begin
      bad++; $display("FAIL f55_overlap: got %0d want 0", overlap_cnt - ob);
    end
  endtask

  task automatic test_glitch;
    int sb = shift_cnt, db = done_cnt, eb = err_cnt, rb = rise_cnt;
    @(negedge clk);
    bus.rx = 1'b0;
    repeat (4) @(negedge clk);
    bus.rx = 1'b1;
    repeat (8) @(negedge clk);
    total++;
    if (bus.busy !== 1'b0) begin
      bad++; $display("FAIL glitch_busy: got %b want 0", bus.busy);
    end
    total++;
    if (rise_cnt - rb !== 1) begin
      bad++; $display("FAIL glitch_start_entry: got %0d want 1", rise_cnt - rb);
    end
    repeat (40) @(negedge clk);
    total++;
    if ((shift_cnt - sb) + (done_cnt - db) + (err_cnt - eb) !== 0) begin
      bad++;
      $display("FAIL glitch_strobes: got shift=%0d done=%0d err=%0d want 0", shift_cnt - sb,
               done_cnt - db, err_cnt - eb);
    end
  endtask

  task automatic test_frame_err;
    int sb = shift_cnt, db = done_cnt, eb = err_cnt, rb = rise_cnt;
    logic [7:0] bits;
    @(negedge clk);
    send_frame(8'hC3, 1'b0);
    repeat (40) @(negedge clk);
    total++;
    if (err_cnt - eb !== 1) begin
      bad++; $display("FAIL ferr_count: got %0d want 1", err_cnt - eb);
    end
    total++;
    if (done_cnt - db !== 0) begin
      bad++; $display("FAIL ferr_rx_done: got %0d want 0", done_cnt - db);
    end
    total++;
    if (shift_cnt - sb !== 8) begin
      bad++; $display("FAIL ferr_shift_count: got %0d want 8", shift_cnt - sb);
    end else begin
      for (int i = 0; i < 8; i++) bits[i] = shift_bit[sb + i];
      total++;
      if (bits !== 8'hC3) begin
        bad++; $display("FAIL ferr_bit_seq: got %h want c3", bits);
      end
    end
    total++;
    if (err_par !== 8'hC3) begin
      bad++; $display("FAIL ferr_par_out: got %h want c3", err_par);
    end
    total++;
    if (bus.busy !== 1'b1) begin
      bad++; $display("FAIL ferr_break_busy: got %b want 1", bus.busy);
    end
    total++;
    if (rise_cnt - rb !== 1) begin
      bad++; $display("FAIL ferr_no_restart: got %0d want 1", rise_cnt - rb);
    end
    bus.rx = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (bus.busy !== 1'b1) begin
      bad++; $display("FAIL ferr_break_hold: got %b want 1", bus.busy);
    end
    repeat (2) @(negedge clk);
    total++;
    if (bus.busy !== 1'b0) begin
      bad++; $display("FAIL ferr_break_exit: got %b want 0", bus.busy);
    end
  endtask

  task automatic test_back_to_back;
    int db = done_cnt, eb = err_cnt, ob = overlap_cnt;
    @(negedge clk);
    send_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    for (int k = 0; k < 50 && done_cnt < db + 2; k++) begin
      @(negedge clk); #1;
    end
    total++;
    if (done_cnt - db !== 2) begin
      bad++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt - db);
    end else begin
      total++;
      if (done_par[db] !== 8'hA3) begin
        bad++; $display("FAIL b2b_first_par: got %h want a3", done_par[db]);
      end
      total++;
      if (done_par[db + 1] !== 8'h0F) begin
        bad++; $display("FAIL b2b_second_par: got %h want 0f", done_par[db + 1]);
      end
    end
    total++;
    if ((err_cnt - eb) + (overlap_cnt - ob) !== 0) begin
      bad++;
      $display("FAIL b2b_err_overlap: got err=%0d overlap=%0d want 0", err_cnt - eb,
               overlap_cnt - ob);
    end
  endtask

  task automatic test_reset_mid_frame;
    int sb = shift_cnt, db = done_cnt, eb = err_cnt;
    @(negedge clk);
    bus.rx = 1'b0;
    repeat (C) @(negedge clk);
    bus.rx = 1'b1;
    for (int k = 0; k < 200 && shift_cnt < sb + 4; k++) begin
      @(negedge clk); #1;
    end
    total++;
    if (shift_cnt - sb !== 4) begin
      bad++; $display("FAIL rstmid_fourth_shift: got %0d want 4", shift_cnt - sb);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.bit_out, bus.shift_en, bus.rx_done, bus.frame_err, bus.busy} !== 5'b0) begin
      bad++;
      $display("FAIL rstmid_outputs: got %b want 00000",
               {bus.bit_out, bus.shift_en, bus.rx_done, bus.frame_err, bus.busy});
    end
    rst = 1'b0;
    repeat (10 * C) @(negedge clk);
    total++;
    if ((done_cnt - db) + (err_cnt - eb) !== 0 || shift_cnt - sb !== 4) begin
      bad++;
      $display("FAIL rstmid_discard: got done=%0d err=%0d shift=%0d want 0 0 4", done_cnt - db,
               err_cnt - eb, shift_cnt - sb);
    end
    send_frame(8'h81, 1'b1);
    for (int k = 0; k < 50 && done_cnt < db + 1; k++) begin
      @(negedge clk); #1;
    end
    total++;
    if (done_cnt - db !== 1) begin
      bad++; $display("FAIL rstmid_next_done: got %0d want 1", done_cnt - db);
    end else begin
      total++;
      if (done_par[db] !== 8'h81) begin
        bad++; $display("FAIL rstmid_next_par: got %h want 81", done_par[db]);
      end
    end
  endtask

  initial begin
    bus.rx = 1'b1;
    test_reset();
    test_frame_55();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid_frame();
    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
